// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU data-port request/response bundle; master = CPU side, slave = memory side
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;
  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );
  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word data-memory responder with WAIT_CYCLES wait states and valid/ready request/response handshakes
// Ports: clk_i, rst_i (async, active high); bus (dmem_responder_if.slave) carries req_*/rsp_*/busy_o.
// Optional DMEM_MISALIGN_CHK_EN rejects addresses with addr[1:0] != 0.
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  dmem_responder_if.slave  bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic        bad;
  logic        accept;
  assign idx = addr_q[IW+1:2];
`ifdef DMEM_MISALIGN_CHK_EN
  assign bad = (addr_q >= 32'(DEPTH_WORDS * 4)) || (addr_q[1:0] != 2'b00);
`else
  assign bad = addr_q >= 32'(DEPTH_WORDS * 4);
`endif
  assign accept = bus.req_valid_i && (state_q == S_IDLE);
  assign bus.req_ready_o = state_q == S_IDLE;
  assign bus.rsp_valid_o = state_q == S_RESP;
  assign bus.busy_o      = state_q != S_IDLE;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      we_d    = bus.req_we_i;
      addr_d  = bus.req_addr_i;
      wdata_d = bus.req_wdata_i;
      cnt_d   = 4'(WAIT_CYCLES);
      state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
    end
    if (state_q == S_WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = (cnt_q <= 4'd1) ? S_ACCESS : S_WAIT;
    end
    if (state_q == S_ACCESS) begin
      rdata_d = (we_q || bad) ? '0 : mem[idx];
      err_d   = bad;
      state_d = S_RESP;
    end
    if (state_q == S_RESP && bus.rsp_ready_i) begin
      rdata_d = '0;
      err_d   = 1'b0;
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // The array is not reset; the async reset moves state_q out of ACCESS, so a reset write never commits.
  always_ff @(posedge clk_i) begin
    if (state_q == S_ACCESS && we_q && !bad) mem[idx] <= wdata_q;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  dmem_responder_if i0();
  dmem_responder_if i1();
  dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) u0 (.clk_i(clk), .rst_i(rst), .bus(i0));
  dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) u1 (.clk_i(clk), .rst_i(rst), .bus(i1));
  always #5 clk = ~clk;
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    i0.req_valid_i = 1'b1;
    i0.req_we_i    = we;
    i0.req_addr_i  = addr;
    i0.req_wdata_i = wd;
    @(posedge clk);
    #1;
    i0.req_valid_i = 1'b0;
    i0.req_wdata_i = 32'hFFFF_FFFF;
    lat = 0;
    while (!i0.rsp_valid_o && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = i0.rsp_rdata_o;
    er = i0.rsp_err_o;
    @(negedge clk);
    i0.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    i0.rsp_ready_i = 1'b0;
  endtask
  task automatic test_reset;
    total++; if (i0.req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", i0.req_ready_o); end
    total++; if (i0.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", i0.rsp_valid_o); end
    total++; if (i0.rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", i0.rsp_rdata_o); end
    total++; if (i0.rsp_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", i0.rsp_err_o); end
    total++; if (i0.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", i0.busy_o); end
    total++; if (i1.req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready1 got %b want 1", i1.req_ready_o); end
  endtask
  task automatic test_write_read;
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b1, 32'h0, 32'hA5A5_0000, rd, er, lat);
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency got %0d want 3", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL wr_err got %b want 0", er); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata got %h want 0", rd); end
    txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got %h want deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL rd_err got %b want 0", er); end
    total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency got %0d want 3", lat); end
  endtask
  task automatic test_backpressure;
    int n;
    @(negedge clk);
    i0.req_valid_i = 1'b1;
    i0.req_we_i    = 1'b0;
    i0.req_addr_i  = 32'h10;
    @(posedge clk);
    #1;
    i0.req_valid_i = 1'b0;
    n = 0;
    while (!i0.rsp_valid_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (n !== 3) begin bad++; $display("FAIL bp_latency got %0d want 3", n); end
    repeat (5) begin
      @(negedge clk);
      total++; if (i0.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid got %b want 1", i0.rsp_valid_o); end
      total++; if (i0.rsp_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bp_rdata got %h want deadbeef", i0.rsp_rdata_o); end
      total++; if (i0.rsp_err_o !== 1'b0) begin bad++; $display("FAIL bp_err got %b want 0", i0.rsp_err_o); end
      total++; if (i0.req_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready got %b want 0", i0.req_ready_o); end
    end
    i0.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    i0.rsp_ready_i = 1'b0;
    total++; if (i0.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL bp_rel_valid got %b want 0", i0.rsp_valid_o); end
    total++; if (i0.req_ready_o !== 1'b1) begin bad++; $display("FAIL bp_rel_ready got %b want 1", i0.req_ready_o); end
    total++; if (i0.busy_o !== 1'b0) begin bad++; $display("FAIL bp_rel_busy got %b want 0", i0.busy_o); end
    total++; if (i0.rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL bp_rel_rdata got %h want 0", i0.rsp_rdata_o); end
  endtask
  task automatic test_out_of_range;
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b1, 32'h200, 32'h55, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_wr_err got %b want 1", er); end
    total++; if (lat !== 3) begin bad++; $display("FAIL oor_latency got %0d want 3", lat); end
    txn(1'b0, 32'h200, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_rd_err got %b want 1", er); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rd_data got %h want 0", rd); end
    txn(1'b0, 32'h0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hA5A5_0000) begin bad++; $display("FAIL oor_word0 got %h want a5a50000", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL oor_word0_err got %b want 0", er); end
    txn(1'b0, 32'h1FC, 32'h0, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL last_word_err got %b want 0", er); end
  endtask
  task automatic test_misalign;
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b0, 32'h12, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_CHK_EN
    total++; if (er !== 1'b1) begin bad++; $display("FAIL mis_err got %b want 1", er); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mis_data got %h want 0", rd); end
`else
    total++; if (er !== 1'b0) begin bad++; $display("FAIL mis_err got %b want 0", er); end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mis_data got %h want deadbeef", rd); end
`endif
    total++; if (lat !== 3) begin bad++; $display("FAIL mis_latency got %0d want 3", lat); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b1, 32'h20, 32'h1111_2222, rd, er, lat);
    @(negedge clk);
    i0.req_valid_i = 1'b1;
    i0.req_we_i    = 1'b1;
    i0.req_addr_i  = 32'h20;
    i0.req_wdata_i = 32'h1234;
    @(posedge clk);
    #1;
    i0.req_valid_i = 1'b0;
    total++; if (i0.busy_o !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", i0.busy_o); end
    rst = 1'b1;
    #1;
    total++; if (i0.busy_o !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got %b want 0", i0.busy_o); end
    total++; if (i0.req_ready_o !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got %b want 1", i0.req_ready_o); end
    total++; if (i0.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got %b want 0", i0.rsp_valid_o); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (i0.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL mid_after_valid got %b want 0", i0.rsp_valid_o); end
    txn(1'b0, 32'h20, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h1111_2222) begin bad++; $display("FAIL mid_old_data got %h want 11112222", rd); end
  endtask
  task automatic test_back_to_back;
    @(negedge clk);
    i1.req_valid_i = 1'b1;
    i1.req_we_i    = 1'b1;
    i1.req_addr_i  = 32'h40;
    i1.req_wdata_i = 32'hCAFE_F00D;
    i1.rsp_ready_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      total++; if (i1.req_ready_o !== (k % 3 == 0)) begin bad++; $display("FAIL b2b_ready[%0d] got %b want %b", k, i1.req_ready_o, (k % 3 == 0)); end
      total++; if (i1.rsp_valid_o !== (k % 3 == 2)) begin bad++; $display("FAIL b2b_valid[%0d] got %b want %b", k, i1.rsp_valid_o, (k % 3 == 2)); end
      if (k == 2) begin
        total++; if (i1.rsp_err_o !== 1'b0) begin bad++; $display("FAIL b2b_wr_err got %b want 0", i1.rsp_err_o); end
      end
      if (k == 5) begin
        total++; if (i1.rsp_rdata_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_rd_data got %h want cafef00d", i1.rsp_rdata_o); end
      end
      if (k == 8) begin
        total++; if (i1.rsp_err_o !== 1'b1) begin bad++; $display("FAIL b2b_oor_err got %b want 1", i1.rsp_err_o); end
        total++; if (i1.rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL b2b_oor_data got %h want 0", i1.rsp_rdata_o); end
      end
      if (k == 1) i1.req_we_i = 1'b0;
      if (k == 4) i1.req_addr_i = 32'h400;
    end
    i1.req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    i1.rsp_ready_i = 1'b0;
    total++; if (i1.req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_end_ready got %b want 1", i1.req_ready_o); end
  endtask
  initial begin
    i0.req_valid_i = 1'b0; i0.req_we_i = 1'b0; i0.req_addr_i = '0; i0.req_wdata_i = '0; i0.rsp_ready_i = 1'b0;
    i1.req_valid_i = 1'b0; i1.req_we_i = 1'b0; i1.req_addr_i = '0; i1.req_wdata_i = '0; i1.rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_write_read;
    test_backpressure;
    test_out_of_range;
    test_misalign;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
